ibm_param: RTL and testbench
============================

IBM_PARAM -- requirements
Module: ibm_param

Interface
REQ-001 Parameter DW, 134: beat width; bits [DW-1:DW-2] are the beat flag (01 head, 11 body, 10 tail).
REQ-002 Parameter TYPE_LSB, 80: LSB of the 8-bit packet-type field in the head beat.
REQ-003 Parameter MDW, 24: metadata width.
REQ-004 Parameter IDW, 8: buffer-ID width; IDW < MDW.
REQ-005 Parameter CW, 5: free-buffer-count width.
REQ-006 Parameter MIN_FREE, 1: minimum free buffers required to accept a packet.
REQ-007 Parameter MD_DLY, 2: cycles from out_ibm_valid_wr to out_ibm_md_wr; range 1..4.
REQ-008 clk  in  1  clock; all logic is clocked on the rising edge.
REQ-009 rst_n  in  1  reset; asynchronous, active-low.
REQ-010 cfg_en  in  1  accept enable; when low, new packets are discarded.
REQ-011 in_ibm_data / in_ibm_data_wr  in  DW / 1  input beat and its strobe.
REQ-012 in_ibm_valid / in_ibm_valid_wr  in  1 / 1  packet-good flag, qualified at the tail.
REQ-013 in_ibm_tsn_md / in_ibm_tsn_md_wr  in  MDW / 1  per-packet metadata and its strobe.
REQ-014 in_ibm_ID / in_ibm_ID_count  in  IDW / CW  allocated buffer ID and free-buffer count.
REQ-015 out_ibm_bufm_ID  out  CW  equals in_ibm_ID_count (combinational).
REQ-016 out_ibm_data / out_ibm_data_wr / out_ibm_valid / out_ibm_valid_wr  out  DW/1/1/1  forwarded packet.
REQ-017 out_ibm_md / out_ibm_md_wr  out  MDW / 1  metadata and its single-cycle strobe.
REQ-018 stat_pkt / stat_filt / stat_nobuf  out  32 each  accepted, type-filtered and no-buffer/disabled drop counts.

Function
REQ-019 States: IDLE, TRANS, DISC.
REQ-020 IDLE, head with in_ibm_data_wr=1:
- Accept -> TRANS when the type field is 1 or >4, cfg_en=1 and in_ibm_ID_count>=MIN_FREE.
- Otherwise -> DISC.
REQ-021 A type-rule failure increments stat_filt; a cfg_en or count failure with a passing type increments stat_nobuf. Exactly one counter increments per rejected head.
REQ-022 Accepted beats appear on out_ibm_data with out_ibm_data_wr=1 exactly 1 cycle after input; all other cycles drive data_wr=0 and data=0.
REQ-023 TRANS, tail with wr=1:
- forward the tail;
- out_ibm_valid=in_ibm_valid and out_ibm_valid_wr=1 in the same cycle as the tail output;
- -> IDLE;
- stat_pkt +1.
REQ-024 TRANS, a new head before any tail: the head is output with its flag replaced by 10, valid=0 and valid_wr=1; -> DISC. stat_pkt does not increment.
REQ-025 DISC: no outputs; -> IDLE on tail with wr=1.
REQ-026 In all states, beats with in_ibm_data_wr=0 are ignored and the state holds.
REQ-027 The tail-to-IDLE path takes 1 cycle; a head on the cycle after a tail is evaluated normally (back-to-back packets).
REQ-028 in_ibm_tsn_md_wr=1 loads a metadata holding register; it is snapshot at head acceptance, so later md_wr pulses do not affect the in-flight packet.
REQ-029 At valid_wr with valid=1, capture {snapshot[MDW-1:IDW], in_ibm_ID}.
- Present it on out_ibm_md with a 1-cycle out_ibm_md_wr pulse exactly MD_DLY cycles later.
- out_ibm_md holds its last value otherwise.
REQ-030 valid=0 packets (including the truncation of REQ-024) produce no md_wr.
REQ-031 The metadata delay line is a shift pipeline, so back-to-back packets each get their own md_wr.
REQ-032 Statistics counters saturate at 2^32-1.
REQ-033 cfg_en changing mid-packet does not affect the packet in flight.

Reset
REQ-034 While rst_n=0: all outputs except out_ibm_bufm_ID are 0, the state is IDLE, and counters, snapshot, holding register and delay line are cleared.
REQ-035 Reset mid-packet abandons the packet; no tail or md_wr is emitted afterwards.

Verification
REQ-036 Head type 1, 3 body beats, tail valid=1, ID_count=3, in_ibm_ID=0x2A, md=0xABCD00 -> 5 beats at +1 cycle; valid_wr with tail; md=0xABCD2A with md_wr 2 cycles later; stat_pkt=1.
REQ-037 Head type 3 -> no output beats; stat_filt=1; the next type-5 packet is forwarded.
REQ-038 Head type 1 with ID_count=0, then the same packet with cfg_en=0 -> both dropped; stat_nobuf=2.
REQ-039 Head, body, then a second head -> truncating beat with flag 10 and valid=0; no md_wr; the remainder is discarded until a tail.
REQ-040 Two 2-beat packets back-to-back, md_wr pulsed between them -> two md_wr pulses, each carrying its own snapshot.
REQ-041 rst_n low during a body beat -> outputs 0 immediately; after release, only the next clean head is forwarded.

Source files
------------

// File: rtl/ibm_param.sv
// Input buffer manager: filters packets by type and buffer availability,
// forwards accepted beats one cycle later and emits per-packet metadata.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_en              accept enable, sampled at packet head
//   in_ibm_data/_wr     input beat and strobe (flag in top two bits)
//   in_ibm_valid/_wr    packet-good flag, meaningful at the tail
//   in_ibm_tsn_md/_wr   per-packet metadata and its load strobe
//   in_ibm_ID/_count    allocated buffer ID and free-buffer count
//   out_ibm_bufm_ID     free-buffer count passed straight through
//   out_ibm_data/...    forwarded beats, valid flag and strobes
//   out_ibm_md/_wr      metadata with single-cycle strobe
//   stat_pkt/filt/nobuf saturating accept / type-drop / no-buffer counters
module ibm_param #(
    parameter int DW       = 134,
    parameter int TYPE_LSB = 80,
    parameter int MDW      = 24,
    parameter int IDW      = 8,
    parameter int CW       = 5,
    parameter int MIN_FREE = 1,
    parameter int MD_DLY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_en,
    input  logic [DW-1:0]   in_ibm_data,
    input  logic            in_ibm_data_wr,
    input  logic            in_ibm_valid,
    input  logic            in_ibm_valid_wr,
    input  logic [MDW-1:0]  in_ibm_tsn_md,
    input  logic            in_ibm_tsn_md_wr,
    input  logic [IDW-1:0]  in_ibm_ID,
    input  logic [CW-1:0]   in_ibm_ID_count,
    output logic [CW-1:0]   out_ibm_bufm_ID,
    output logic [DW-1:0]   out_ibm_data,
    output logic            out_ibm_data_wr,
    output logic            out_ibm_valid,
    output logic            out_ibm_valid_wr,
    output logic [MDW-1:0]  out_ibm_md,
    output logic            out_ibm_md_wr,
    output logic [31:0]     stat_pkt,
    output logic [31:0]     stat_filt,
    output logic [31:0]     stat_nobuf
);

    typedef enum logic [1:0] {
        IDLE,
        TRANS,
        DISC
    } state_t;

    localparam logic [1:0] F_HEAD = 2'b01;
    localparam logic [1:0] F_TAIL = 2'b10;

    state_t              state;
    logic [1:0]          flag;
    logic                is_head;
    logic                is_tail;
    logic [7:0]          ptype;
    logic                type_ok;
    logic                buf_ok;
    logic                cap;
    logic [MDW-IDW-1:0]  md_hold;
    logic [MDW-IDW-1:0]  md_snap;
    logic [MD_DLY-1:0]   pipe_v;
    logic [MDW-1:0]      pipe_d [MD_DLY];

    // The low metadata bits are replaced by the buffer ID, so they are
    // never stored; the tail strobe carries no information beyond the beat.
    logic unused_in;
    assign unused_in = ^{in_ibm_tsn_md[IDW-1:0], in_ibm_valid_wr};

    assign out_ibm_bufm_ID = in_ibm_ID_count;

    assign flag    = in_ibm_data[DW-1:DW-2];
    assign is_head = in_ibm_data_wr && (flag == F_HEAD);
    assign is_tail = in_ibm_data_wr && (flag == F_TAIL);
    assign ptype   = in_ibm_data[TYPE_LSB +: 8];
    assign type_ok = (ptype == 8'd1) || (ptype > 8'd4);
    assign buf_ok  = cfg_en && (in_ibm_ID_count >= CW'(MIN_FREE));

    // A good tail leaving TRANS launches one metadata token.
    assign cap = (state == TRANS) && is_tail && in_ibm_valid;

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (&c) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            out_ibm_data     <= '0;
            out_ibm_data_wr  <= 1'b0;
            out_ibm_valid    <= 1'b0;
            out_ibm_valid_wr <= 1'b0;
            md_hold          <= '0;
            md_snap          <= '0;
            stat_pkt         <= '0;
            stat_filt        <= '0;
            stat_nobuf       <= '0;
        end else begin
            out_ibm_data     <= '0;
            out_ibm_data_wr  <= 1'b0;
            out_ibm_valid    <= 1'b0;
            out_ibm_valid_wr <= 1'b0;
            if (in_ibm_tsn_md_wr) begin
                md_hold <= in_ibm_tsn_md[MDW-1:IDW];
            end
            if (in_ibm_data_wr) begin
                unique case (state)
                    IDLE: begin
                        if (is_head) begin
                            if (type_ok && buf_ok) begin
                                state           <= TRANS;
                                md_snap         <= md_hold;
                                out_ibm_data    <= in_ibm_data;
                                out_ibm_data_wr <= 1'b1;
                            end else begin
                                state <= DISC;
                                if (!type_ok) begin
                                    stat_filt <= sat_inc(stat_filt);
                                end else begin
                                    stat_nobuf <= sat_inc(stat_nobuf);
                                end
                            end
                        end
                    end
                    TRANS: begin
                        out_ibm_data_wr <= 1'b1;
                        if (is_tail) begin
                            out_ibm_data     <= in_ibm_data;
                            out_ibm_valid    <= in_ibm_valid;
                            out_ibm_valid_wr <= 1'b1;
                            state            <= IDLE;
                            stat_pkt         <= sat_inc(stat_pkt);
                        end else if (is_head) begin
                            // Unexpected head: close the open packet as bad
                            out_ibm_data     <= {F_TAIL, in_ibm_data[DW-3:0]};
                            out_ibm_valid_wr <= 1'b1;
                            state            <= DISC;
                        end else begin
                            out_ibm_data <= in_ibm_data;
                        end
                    end
                    DISC: begin
                        if (is_tail) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stage 0 lines up with out_ibm_valid_wr; the output register adds
    // the final cycle so the strobe lands MD_DLY cycles after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v        <= '0;
            out_ibm_md    <= '0;
            out_ibm_md_wr <= 1'b0;
            for (int i = 0; i < MD_DLY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= cap;
            if (cap) begin
                pipe_d[0] <= {md_snap, in_ibm_ID};
            end
            for (int i = 1; i < MD_DLY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            out_ibm_md_wr <= pipe_v[MD_DLY-1];
            if (pipe_v[MD_DLY-1]) begin
                out_ibm_md <= pipe_d[MD_DLY-1];
            end
        end
    end

endmodule

// File: tb/tb_ibm_param.sv
// Testbench for ibm_param: directed scenarios plus random beat streams,
// checked cycle by cycle against a packet-level reference model.
module tb_ibm_param;

    localparam int DW       = 134;
    localparam int TYPE_LSB = 80;
    localparam int MDW      = 24;
    localparam int IDW      = 8;
    localparam int CW       = 5;
    localparam int MIN_FREE = 1;
    localparam int MD_DLY   = 2;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b11;
    localparam logic [1:0] TAIL = 2'b10;

    logic            clk;
    logic            rst_n;
    logic            cfg_en;
    logic [DW-1:0]   in_ibm_data;
    logic            in_ibm_data_wr;
    logic            in_ibm_valid;
    logic            in_ibm_valid_wr;
    logic [MDW-1:0]  in_ibm_tsn_md;
    logic            in_ibm_tsn_md_wr;
    logic [IDW-1:0]  in_ibm_ID;
    logic [CW-1:0]   in_ibm_ID_count;
    logic [CW-1:0]   out_ibm_bufm_ID;
    logic [DW-1:0]   out_ibm_data;
    logic            out_ibm_data_wr;
    logic            out_ibm_valid;
    logic            out_ibm_valid_wr;
    logic [MDW-1:0]  out_ibm_md;
    logic            out_ibm_md_wr;
    logic [31:0]     stat_pkt;
    logic [31:0]     stat_filt;
    logic [31:0]     stat_nobuf;

    ibm_param #(
        .DW(DW), .TYPE_LSB(TYPE_LSB), .MDW(MDW), .IDW(IDW),
        .CW(CW), .MIN_FREE(MIN_FREE), .MD_DLY(MD_DLY)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_en(cfg_en),
        .in_ibm_data(in_ibm_data),
        .in_ibm_data_wr(in_ibm_data_wr),
        .in_ibm_valid(in_ibm_valid),
        .in_ibm_valid_wr(in_ibm_valid_wr),
        .in_ibm_tsn_md(in_ibm_tsn_md),
        .in_ibm_tsn_md_wr(in_ibm_tsn_md_wr),
        .in_ibm_ID(in_ibm_ID),
        .in_ibm_ID_count(in_ibm_ID_count),
        .out_ibm_bufm_ID(out_ibm_bufm_ID),
        .out_ibm_data(out_ibm_data),
        .out_ibm_data_wr(out_ibm_data_wr),
        .out_ibm_valid(out_ibm_valid),
        .out_ibm_valid_wr(out_ibm_valid_wr),
        .out_ibm_md(out_ibm_md),
        .out_ibm_md_wr(out_ibm_md_wr),
        .stat_pkt(stat_pkt),
        .stat_filt(stat_filt),
        .stat_nobuf(stat_nobuf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int md_seen = 0;

    // Expected output per cycle: {valid_wr, valid, data} and metadata.
    logic [DW+1:0]  exp_b [int];
    logic [MDW-1:0] exp_m [int];
    logic [MDW-1:0] md_last = '0;

    // Packet-level reference model
    bit             m_fwd  = 0;
    bit             m_drop = 0;
    logic [MDW-1:0] m_hold = '0;
    logic [MDW-1:0] m_snap = '0;
    int unsigned    e_pkt  = 0;
    int unsigned    e_filt = 0;
    int unsigned    e_nobuf = 0;

    task automatic model_reset();
        m_fwd   = 0;
        m_drop  = 0;
        m_hold  = '0;
        m_snap  = '0;
        e_pkt   = 0;
        e_filt  = 0;
        e_nobuf = 0;
        md_last = '0;
        exp_b.delete();
        exp_m.delete();
    endtask

    task automatic model_step(input int c);
        logic [1:0] f;
        int         t;
        bit         good_type;
        bit         room;
        f = in_ibm_data[DW-1:DW-2];
        t = int'(in_ibm_data[TYPE_LSB +: 8]);
        if (in_ibm_data_wr) begin
            if (m_fwd) begin
                if (f == TAIL) begin
                    exp_b[c+1] = {1'b1, in_ibm_valid, in_ibm_data};
                    if (in_ibm_valid)
                        exp_m[c+1+MD_DLY] = {m_snap[MDW-1:IDW], in_ibm_ID};
                    e_pkt++;
                    m_fwd = 0;
                end else if (f == HEAD) begin
                    exp_b[c+1] = {1'b1, 1'b0, TAIL, in_ibm_data[DW-3:0]};
                    m_fwd  = 0;
                    m_drop = 1;
                end else begin
                    exp_b[c+1] = {1'b0, 1'b0, in_ibm_data};
                end
            end else if (m_drop) begin
                if (f == TAIL) m_drop = 0;
            end else if (f == HEAD) begin
                good_type = (t == 1) || (t > 4);
                room = cfg_en && (int'(in_ibm_ID_count) >= MIN_FREE);
                if (good_type && room) begin
                    m_fwd  = 1;
                    m_snap = m_hold;
                    exp_b[c+1] = {1'b0, 1'b0, in_ibm_data};
                end else begin
                    m_drop = 1;
                    if (!good_type) e_filt++;
                    else e_nobuf++;
                end
            end
        end
        if (in_ibm_tsn_md_wr) m_hold = in_ibm_tsn_md;
    endtask

    always @(negedge clk) begin : mon
        logic [DW+1:0] eb;
        logic          ew;
        logic          em;
        ew = exp_b.exists(cyc) != 0;
        eb = ew ? exp_b[cyc] : '0;
        if (ew) exp_b.delete(cyc);
        em = exp_m.exists(cyc) != 0;
        if (em) begin
            md_last = exp_m[cyc];
            exp_m.delete(cyc);
        end
        if (out_ibm_md_wr === 1'b1) md_seen++;
        n_chk++;
        if ({out_ibm_data_wr, out_ibm_valid_wr, out_ibm_valid, out_ibm_data}
            !== {ew, eb})
            $display("FAIL beat @%0d: got wr=%b vwr=%b v=%b d=%h want wr=%b vwr=%b v=%b d=%h",
                     cyc, out_ibm_data_wr, out_ibm_valid_wr, out_ibm_valid,
                     out_ibm_data, ew, eb[DW+1], eb[DW], eb[DW-1:0]);
        else n_pass++;
        n_chk++;
        if ({out_ibm_md_wr, out_ibm_md} !== {em, md_last})
            $display("FAIL md @%0d: got wr=%b md=%h want wr=%b md=%h",
                     cyc, out_ibm_md_wr, out_ibm_md, em, md_last);
        else n_pass++;
    end

    task automatic drive(input bit wr, input logic [1:0] f,
                         input logic [7:0] t, input bit v);
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        in_ibm_data = r[DW-1:0];
        in_ibm_data[DW-1:DW-2] = f;
        in_ibm_data[TYPE_LSB +: 8] = t;
        in_ibm_data_wr  = wr;
        in_ibm_valid    = v;
        in_ibm_valid_wr = wr && (f == TAIL);
        if (rst_n) model_step(cyc);
        @(posedge clk);
        #1;
        in_ibm_data      = '0;
        in_ibm_data_wr   = 1'b0;
        in_ibm_valid     = 1'b0;
        in_ibm_valid_wr  = 1'b0;
        in_ibm_tsn_md_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, BODY, 8'd0, 0);
    endtask

    task automatic pulse_md(input logic [MDW-1:0] v);
        in_ibm_tsn_md    = v;
        in_ibm_tsn_md_wr = 1'b1;
    endtask

    task automatic check_stats(input string name);
        n_chk++;
        if ({stat_pkt, stat_filt, stat_nobuf} !== {e_pkt, e_filt, e_nobuf})
            $display("FAIL %s stats: got %0d/%0d/%0d want %0d/%0d/%0d", name,
                     stat_pkt, stat_filt, stat_nobuf, e_pkt, e_filt, e_nobuf);
        else n_pass++;
    endtask

    task automatic test_reset();
        in_ibm_ID_count = 5'd7;
        idle(2);
        n_chk++;
        if ({out_ibm_data_wr, out_ibm_valid_wr, out_ibm_valid, out_ibm_md_wr,
             out_ibm_data, out_ibm_md} !== '0)
            $display("FAIL reset_outputs: got d=%h md=%h want 0",
                     out_ibm_data, out_ibm_md);
        else n_pass++;
        n_chk++;
        if ({stat_pkt, stat_filt, stat_nobuf} !== 96'd0)
            $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0",
                     stat_pkt, stat_filt, stat_nobuf);
        else n_pass++;
        n_chk++;
        if (out_ibm_bufm_ID !== 5'd7)
            $display("FAIL bufm_passthru: got %0d want 7", out_ibm_bufm_ID);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        idle(2);
    endtask

    task automatic test_basic();
        cfg_en = 1'b1;
        in_ibm_ID_count = 5'd3;
        in_ibm_ID = 8'h2A;
        pulse_md(24'hABCD00);
        idle(1);
        drive(1, HEAD, 8'd1, 0);
        repeat (3) drive(1, BODY, 8'd1, 0);
        drive(1, TAIL, 8'd1, 1);
        idle(MD_DLY + 3);
        n_chk++;
        if (stat_pkt !== 32'd1)
            $display("FAIL basic_pkt: got %0d want 1", stat_pkt);
        else n_pass++;
        n_chk++;
        if (out_ibm_md !== 24'hABCD2A)
            $display("FAIL basic_md: got %h want abcd2a", out_ibm_md);
        else n_pass++;
        n_chk++;
        if (out_ibm_bufm_ID !== 5'd3)
            $display("FAIL bufm_track: got %0d want 3", out_ibm_bufm_ID);
        else n_pass++;
    endtask

    task automatic test_filter();
        drive(1, HEAD, 8'd3, 0);
        drive(1, BODY, 8'd3, 0);
        drive(1, TAIL, 8'd3, 1);
        idle(2);
        n_chk++;
        if (stat_filt !== 32'd1)
            $display("FAIL filt_count: got %0d want 1", stat_filt);
        else n_pass++;
        drive(1, HEAD, 8'd5, 0);
        drive(1, TAIL, 8'd5, 1);
        idle(MD_DLY + 2);
        n_chk++;
        if (stat_pkt !== 32'd2)
            $display("FAIL filt_next_pkt: got %0d want 2", stat_pkt);
        else n_pass++;
    endtask

    task automatic test_nobuf();
        in_ibm_ID_count = 5'd0;
        drive(1, HEAD, 8'd1, 0);
        drive(1, BODY, 8'd1, 0);
        drive(1, TAIL, 8'd1, 1);
        in_ibm_ID_count = 5'd3;
        cfg_en = 1'b0;
        drive(1, HEAD, 8'd1, 0);
        drive(1, BODY, 8'd1, 0);
        drive(1, TAIL, 8'd1, 1);
        cfg_en = 1'b1;
        idle(MD_DLY + 2);
        n_chk++;
        if (stat_nobuf !== 32'd2)
            $display("FAIL nobuf_count: got %0d want 2", stat_nobuf);
        else n_pass++;
        check_stats("nobuf");
    endtask

    task automatic test_truncate();
        int seen0;
        seen0 = md_seen;
        drive(1, HEAD, 8'd6, 0);
        cfg_en = 1'b0;
        drive(1, BODY, 8'd6, 0);
        drive(1, HEAD, 8'd1, 1);
        cfg_en = 1'b1;
        drive(1, BODY, 8'd1, 0);
        drive(1, TAIL, 8'd1, 1);
        idle(MD_DLY + 3);
        n_chk++;
        if (md_seen != seen0)
            $display("FAIL trunc_no_md: got %0d pulses want 0", md_seen - seen0);
        else n_pass++;
        check_stats("truncate");
    endtask

    task automatic test_back_to_back();
        int seen0;
        seen0 = md_seen;
        pulse_md(24'h111100);
        idle(1);
        in_ibm_ID = 8'h01;
        drive(1, HEAD, 8'd9, 0);
        pulse_md(24'h222200);
        drive(1, TAIL, 8'd9, 1);
        in_ibm_ID = 8'h02;
        drive(1, HEAD, 8'd1, 0);
        drive(1, TAIL, 8'd1, 1);
        idle(MD_DLY + 3);
        n_chk++;
        if (md_seen - seen0 != 2)
            $display("FAIL b2b_md_pulses: got %0d want 2", md_seen - seen0);
        else n_pass++;
        n_chk++;
        if (out_ibm_md !== 24'h222202)
            $display("FAIL b2b_last_md: got %h want 222202", out_ibm_md);
        else n_pass++;
        check_stats("b2b");
    endtask

    task automatic test_midreset();
        int seen0;
        drive(1, HEAD, 8'd7, 0);
        drive(1, BODY, 8'd7, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({out_ibm_data_wr, out_ibm_valid_wr, out_ibm_data} !== '0)
            $display("FAIL async_reset: got wr=%b d=%h want 0",
                     out_ibm_data_wr, out_ibm_data);
        else n_pass++;
        drive(1, BODY, 8'd7, 0);
        drive(1, BODY, 8'd7, 0);
        rst_n = 1'b1;
        seen0 = md_seen;
        drive(1, BODY, 8'd7, 0);
        drive(1, TAIL, 8'd7, 1);
        drive(1, HEAD, 8'd1, 0);
        drive(1, TAIL, 8'd1, 1);
        idle(MD_DLY + 3);
        n_chk++;
        if (md_seen - seen0 != 1)
            $display("FAIL midreset_md: got %0d want 1", md_seen - seen0);
        else n_pass++;
        n_chk++;
        if (stat_pkt !== 32'd1)
            $display("FAIL midreset_pkt: got %0d want 1", stat_pkt);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] types [8];
        logic [1:0] flags [3];
        types = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd200};
        flags = '{HEAD, BODY, TAIL};
        for (int i = 0; i < 600; i++) begin
            cfg_en = ($urandom_range(0, 7) != 0);
            in_ibm_ID_count = CW'($urandom_range(0, 3));
            in_ibm_ID = IDW'($urandom());
            if ($urandom_range(0, 4) == 0) pulse_md(MDW'($urandom()));
            drive($urandom_range(0, 3) != 0,
                  flags[$urandom_range(0, 2)],
                  types[$urandom_range(0, 7)],
                  $urandom_range(0, 1) != 0);
        end
        idle(MD_DLY + 3);
        check_stats("random");
    endtask

    initial begin
        rst_n            = 1'b0;
        cfg_en           = 1'b0;
        in_ibm_data      = '0;
        in_ibm_data_wr   = 1'b0;
        in_ibm_valid     = 1'b0;
        in_ibm_valid_wr  = 1'b0;
        in_ibm_tsn_md    = '0;
        in_ibm_tsn_md_wr = 1'b0;
        in_ibm_ID        = '0;
        in_ibm_ID_count  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_filter();
        test_nobuf();
        test_truncate();
        test_back_to_back();
        test_midreset();
        test_random();
        n_chk++;
        if (exp_b.num() != 0 || exp_m.num() != 0)
            $display("FAIL leftover: beats=%0d md=%0d want 0/0",
                     exp_b.num(), exp_m.num());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
